// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client (I-cache / D-cache) arbiter in front of a single shared,
// multi-cycle main memory. One client owns the memory at a time; a read grant is held
// until the owner stops requesting and all of its in-flight reads have returned.
// D-cache stores are issued for one cycle and acknowledged with a d_wdone pulse.
module mem_arbiter #(
    parameter int RD_LAT  = 4,   // memory read latency (request to mem_data_valid)
    parameter int WR_LAT  = 4,   // cycles from the mem_wr issue cycle to d_wdone
    parameter int MAX_OUT = 8    // maximum outstanding reads
) (
    input  logic        clk,
    input  logic        rst_n,
    // I-cache port
    input  logic [15:0] i_addr,
    input  logic        i_re,
    output logic [15:0] i_din,
    output logic        i_data_valid,
    // D-cache port
    input  logic [15:0] d_addr,
    input  logic        d_re,
    input  logic        d_we,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_din,
    output logic        d_data_valid,
    output logic        d_wdone,
    // main memory port
    output logic [15:0] mem_addr,
    output logic        mem_re,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_data_valid
);

    // The outstanding and write-wait counters are 4 bits wide.
    if (RD_LAT < 1 || WR_LAT < 2 || WR_LAT > 16 || MAX_OUT < 1 || MAX_OUT > 15) begin : g_param_check
        $error("mem_arbiter: unsupported parameter values");
    end

    localparam logic [3:0] OUT_MAX  = 4'(MAX_OUT);
    localparam logic [3:0] WR_LAST  = 4'(WR_LAT - 1);

    // DWR_ISSUE is a reserved encoding: the store is issued from IDLE in the grant
    // cycle itself, so the state is never entered and falls back to IDLE if it is.
    typedef enum logic [2:0] {
        IDLE,
        GNT_I,
        GNT_DR,
        DWR_ISSUE,
        DWR_WAIT
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] outstanding_reg, outstanding_next;
    logic [3:0] wr_cnt_reg, wr_cnt_next;
    logic       ret_accept;

    // Saturating up/down count of reads issued but not yet returned.
    function automatic logic [3:0] count_next(input logic [3:0] cnt,
                                              input logic inc,
                                              input logic dec);
        logic [3:0] r;
        r = cnt;
        if (inc && !dec) begin
            r = (cnt >= OUT_MAX) ? OUT_MAX : cnt + 4'd1;
        end else if (dec && !inc) begin
            r = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        end
        return r;
    endfunction

    // State, outstanding-read count and write-wait count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            outstanding_reg <= 4'd0;
            wr_cnt_reg      <= 4'd0;
        end else begin
            state_reg       <= state_next;
            outstanding_reg <= outstanding_next;
            wr_cnt_reg      <= wr_cnt_next;
        end
    end

    // Arbitration, memory command muxing, read-data routing and next-state logic.
    always_comb begin
        state_next       = state_reg;
        outstanding_next = outstanding_reg;
        wr_cnt_next      = wr_cnt_reg;
        mem_re           = 1'b0;
        mem_wr           = 1'b0;
        mem_addr         = 16'h0000;
        mem_wdata        = 16'h0000;
        i_din            = 16'h0000;
        i_data_valid     = 1'b0;
        d_din            = 16'h0000;
        d_data_valid     = 1'b0;
        d_wdone          = 1'b0;
        // A return is only meaningful while a read grant has reads in flight.
        ret_accept       = mem_data_valid && (outstanding_reg != 4'd0);

        case (state_reg)
            IDLE: begin
                // Zero-latency arbitration; the rst_n gate keeps every output low
                // while reset is held even though requests may be active.
                outstanding_next = 4'd0;
                wr_cnt_next      = 4'd0;
                if (rst_n) begin
                    if (d_we) begin
                        mem_wr      = 1'b1;
                        mem_addr    = d_addr;
                        mem_wdata   = d_wdata;
                        wr_cnt_next = 4'd1;
                        state_next  = DWR_WAIT;
                    end else if (d_re) begin
                        mem_re           = 1'b1;
                        mem_addr         = d_addr;
                        outstanding_next = 4'd1;
                        state_next       = GNT_DR;
                    end else if (i_re) begin
                        mem_re           = 1'b1;
                        mem_addr         = i_addr;
                        outstanding_next = 4'd1;
                        state_next       = GNT_I;
                    end
                end
            end

            GNT_I: begin
                mem_re           = i_re;
                mem_addr         = i_addr;
                i_data_valid     = ret_accept;
                i_din            = ret_accept ? mem_rdata : 16'h0000;
                outstanding_next = count_next(outstanding_reg, i_re, ret_accept);
                if (!i_re && outstanding_next == 4'd0) begin
                    state_next = IDLE;
                end
            end

            GNT_DR: begin
                mem_re           = d_re;
                mem_addr         = d_addr;
                d_data_valid     = ret_accept;
                d_din            = ret_accept ? mem_rdata : 16'h0000;
                outstanding_next = count_next(outstanding_reg, d_re, ret_accept);
                if (!d_re && outstanding_next == 4'd0) begin
                    state_next = IDLE;
                end
            end

            DWR_WAIT: begin
                // The store was issued on entry; wait out the write latency.
                if (wr_cnt_reg >= WR_LAST) begin
                    d_wdone     = 1'b1;
                    wr_cnt_next = 4'd0;
                    state_next  = IDLE;
                end else begin
                    wr_cnt_next = wr_cnt_reg + 4'd1;
                end
            end

            default: begin
                state_next       = IDLE;
                outstanding_next = 4'd0;
                wr_cnt_next      = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven arbitration vectors plus hand-written multi-cycle
// sequences; a behavioural memory returns reads RD_LAT cycles after issue and a
// scoreboard of expected read words is popped as each client sees its data.
module tb_mem_arbiter;

    localparam int RD_LAT  = 4;
    localparam int WR_LAT  = 4;
    localparam int MAX_OUT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_re, d_re, d_we;
    logic [15:0] i_din, d_din;
    logic        i_data_valid, d_data_valid, d_wdone;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_re, mem_wr, mem_data_valid;

    logic        model_valid, stray_valid;
    logic [15:0] model_data, stray_data;

    assign mem_data_valid = model_valid | stray_valid;
    assign mem_rdata      = model_valid ? model_data : stray_data;

    mem_arbiter #(.RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .MAX_OUT(MAX_OUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_addr         (i_addr),
        .i_re           (i_re),
        .i_din          (i_din),
        .i_data_valid   (i_data_valid),
        .d_addr         (d_addr),
        .d_re           (d_re),
        .d_we           (d_we),
        .d_wdata        (d_wdata),
        .d_din          (d_din),
        .d_data_valid   (d_data_valid),
        .d_wdone        (d_wdone),
        .mem_addr       (mem_addr),
        .mem_re         (mem_re),
        .mem_wr         (mem_wr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_data_valid (mem_data_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_i[$];
    logic [15:0] exp_d[$];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural memory: a read seen in cycle t returns in cycle t+RD_LAT.
    logic [15:0] pend_addr[$];
    int          pend_due[$];
    int          mem_cyc = 0;
    initial begin
        model_valid = 1'b0;
        model_data  = 16'h0000;
        forever begin
            @(negedge clk);
            if (mem_re === 1'b1) begin
                pend_addr.push_back(mem_addr);
                pend_due.push_back(mem_cyc + RD_LAT);
            end
            @(posedge clk);
            #1;
            mem_cyc++;
            model_valid = 1'b0;
            model_data  = 16'h0000;
            if (pend_due.size() > 0 && pend_due[0] == mem_cyc) begin
                model_valid = 1'b1;
                model_data  = mem_word(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
        end
    end

    // Scoreboard and always-true invariants, sampled mid-cycle.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            chk(!(mem_re === 1'b1 && mem_wr === 1'b1), "re_wr_exclusive", {mem_re, mem_wr}, 2'b00);
            if (i_data_valid === 1'b1) begin
                if (exp_i.size() == 0) begin
                    chk(1'b0, "i_unexpected_valid", i_din, 0);
                end else begin
                    e = exp_i.pop_front();
                    chk(i_din === e, "i_din", i_din, e);
                end
            end else begin
                chk(i_din === 16'h0000, "i_din_zero_when_idle", i_din, 0);
            end
            if (d_data_valid === 1'b1) begin
                if (exp_d.size() == 0) begin
                    chk(1'b0, "d_unexpected_valid", d_din, 0);
                end else begin
                    e = exp_d.pop_front();
                    chk(d_din === e, "d_din", d_din, e);
                end
            end else begin
                chk(d_din === 16'h0000, "d_din_zero_when_idle", d_din, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        i_re;
        logic        d_re;
        logic        d_we;
        logic [15:0] i_addr;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic        x_re;
        logic        x_wr;
        logic [15:0] x_addr;
        logic [15:0] x_wdata;
    } vec_t;

    task automatic clear_inputs();
        i_re = 1'b0; d_re = 1'b0; d_we = 1'b0;
        i_addr = 16'h0000; d_addr = 16'h0000; d_wdata = 16'h0000;
        stray_valid = 1'b0; stray_data = 16'h0000;
    endtask

    initial begin
        vec_t vecs[8];
        logic [68:0] all_out;

        vecs[0] = '{1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b1, 16'h2222, 16'h3333};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h0A10, 16'h2222, 16'h3333, 1'b1, 1'b0, 16'h0A10, 16'h0000};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h0A10, 16'h0B20, 16'h3333, 1'b1, 1'b0, 16'h0B20, 16'h0000};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 16'h0A10, 16'h0C30, 16'hCAFE, 1'b0, 1'b1, 16'h0C30, 16'hCAFE};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h0A10, 16'h0D40, 16'h3333, 1'b1, 1'b0, 16'h0D40, 16'h0000};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 16'h0A10, 16'h0E50, 16'hF00D, 1'b0, 1'b1, 16'h0E50, 16'hF00D};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 16'h0A10, 16'h0F60, 16'h7777, 1'b0, 1'b1, 16'h0F60, 16'h7777};

        rst_n = 1'b0;
        clear_inputs();
        step();

        // Table: requests held during reset give all-zero outputs; after release
        // the IDLE winner drives the memory port in the same cycle.
        for (int v = 0; v < 8; v++) begin
            rst_n   = 1'b0;
            i_re    = vecs[v].i_re;
            d_re    = vecs[v].d_re;
            d_we    = vecs[v].d_we;
            i_addr  = vecs[v].i_addr;
            d_addr  = vecs[v].d_addr;
            d_wdata = vecs[v].d_wdata;
            @(negedge clk);
            all_out = {mem_re, mem_wr, mem_addr, mem_wdata, i_data_valid, i_din,
                       d_data_valid, d_din, d_wdone};
            chk(all_out === 69'd0, "vec_reset_outputs", all_out, 0);
            repeat (5) step();
            rst_n = 1'b1;
            @(negedge clk);
            chk(mem_re === vecs[v].x_re, "vec_mem_re", mem_re, vecs[v].x_re);
            chk(mem_wr === vecs[v].x_wr, "vec_mem_wr", mem_wr, vecs[v].x_wr);
            if (vecs[v].x_re || vecs[v].x_wr)
                chk(mem_addr === vecs[v].x_addr, "vec_mem_addr", mem_addr, vecs[v].x_addr);
            if (vecs[v].x_wr)
                chk(mem_wdata === vecs[v].x_wdata, "vec_mem_wdata", mem_wdata, vecs[v].x_wdata);
            step();
            clear_inputs();
        end
        rst_n = 1'b0;
        repeat (6) step();
        rst_n = 1'b1;
        repeat (2) step();

        // I fill of 8 words; a D read probed just before and just after release.
        for (int k = 0; k < 20; k++) begin
            i_re = (k < 8);
            if (k < 8) begin
                i_addr = 16'h0100 + 16'(2 * k);
                exp_i.push_back(mem_word(i_addr));
            end
            d_re   = (k == 11 || k == 12);
            d_addr = 16'h3000;
            if (k == 12) exp_d.push_back(mem_word(16'h3000));
            @(negedge clk);
            chk(mem_re === ((k < 8) || (k == 12)), "fill_mem_re", mem_re, (k < 8) || (k == 12));
            if (k < 8)   chk(mem_addr === i_addr, "fill_mem_addr", mem_addr, i_addr);
            if (k == 12) chk(mem_addr === 16'h3000, "fill_probe_addr", mem_addr, 16'h3000);
            chk(i_data_valid === (k >= 4 && k <= 11), "fill_i_valid", i_data_valid, (k >= 4 && k <= 11));
            chk(d_data_valid === (k == 16), "fill_d_valid", d_data_valid, (k == 16));
            step();
        end
        clear_inputs();
        repeat (3) step();

        // I and D read requests rise together: D burst first, then I.
        for (int k = 0; k < 28; k++) begin
            d_re = (k < 8);
            if (k < 8) begin
                d_addr = 16'h4000 + 16'(k);
                exp_d.push_back(mem_word(d_addr));
            end
            i_re   = (k < 20);
            i_addr = (k < 12) ? 16'h0200 : 16'h0200 + 16'(2 * (k - 12));
            if (k >= 12 && k < 20) exp_i.push_back(mem_word(i_addr));
            @(negedge clk);
            chk(mem_re === ((k < 8) || (k >= 12 && k < 20)), "both_mem_re", mem_re,
                (k < 8) || (k >= 12 && k < 20));
            if (k < 8)             chk(mem_addr === d_addr, "both_d_addr", mem_addr, d_addr);
            if (k >= 12 && k < 20) chk(mem_addr === i_addr, "both_i_addr", mem_addr, i_addr);
            chk(d_data_valid === (k >= 4 && k <= 11), "both_d_valid", d_data_valid, (k >= 4 && k <= 11));
            chk(i_data_valid === (k >= 16 && k <= 23), "both_i_valid", i_data_valid, (k >= 16 && k <= 23));
            step();
        end
        clear_inputs();
        repeat (3) step();

        // Single store with an I read request arriving during the write wait.
        for (int k = 0; k < 8; k++) begin
            d_we    = (k < 4);
            d_addr  = 16'h2000;
            d_wdata = 16'hBEEF;
            i_re    = (k >= 1 && k <= 3);
            i_addr  = 16'h0500;
            @(negedge clk);
            chk(mem_wr === (k == 0), "wr_mem_wr", mem_wr, (k == 0));
            if (k == 0) begin
                chk(mem_addr === 16'h2000, "wr_mem_addr", mem_addr, 16'h2000);
                chk(mem_wdata === 16'hBEEF, "wr_mem_wdata", mem_wdata, 16'hBEEF);
            end
            chk(mem_re === 1'b0, "wr_no_mem_re", mem_re, 0);
            chk(d_wdone === (k == WR_LAT - 1), "wr_wdone", d_wdone, (k == WR_LAT - 1));
            step();
        end
        clear_inputs();
        repeat (2) step();

        // Store requested in the 3rd cycle of an I fill waits for the fill to drain.
        for (int k = 0; k < 20; k++) begin
            i_re = (k < 8);
            if (k < 8) begin
                i_addr = 16'h0600 + 16'(2 * k);
                exp_i.push_back(mem_word(i_addr));
            end
            d_we    = (k >= 2 && k < 16);
            d_addr  = 16'h2468;
            d_wdata = 16'h1357;
            @(negedge clk);
            chk(mem_re === (k < 8), "wfill_mem_re", mem_re, (k < 8));
            chk(mem_wr === (k == 12), "wfill_mem_wr", mem_wr, (k == 12));
            if (k == 12) begin
                chk(mem_addr === 16'h2468, "wfill_mem_addr", mem_addr, 16'h2468);
                chk(mem_wdata === 16'h1357, "wfill_mem_wdata", mem_wdata, 16'h1357);
            end
            chk(d_wdone === (k == 15), "wfill_wdone", d_wdone, (k == 15));
            chk(i_data_valid === (k >= 4 && k <= 11), "wfill_i_valid", i_data_valid, (k >= 4 && k <= 11));
            step();
        end
        clear_inputs();
        repeat (3) step();

        // Reset with 3 reads outstanding; late and stray returns are dropped.
        for (int k = 0; k < 18; k++) begin
            rst_n       = (k != 3);
            i_re        = (k < 3) || (k == 12);
            i_addr      = (k == 12) ? 16'h0400 : 16'h0300 + 16'(2 * k);
            stray_valid = (k == 8);
            stray_data  = 16'h1234;
            if (k == 12) exp_i.push_back(mem_word(16'h0400));
            @(negedge clk);
            if (k == 3) begin
                all_out = {mem_re, mem_wr, mem_addr, mem_wdata, i_data_valid, i_din,
                           d_data_valid, d_din, d_wdone};
                chk(all_out === 69'd0, "rstmid_outputs", all_out, 0);
            end
            chk(i_data_valid === (k == 16), "rstmid_i_valid", i_data_valid, (k == 16));
            chk(d_data_valid === 1'b0, "rstmid_d_valid", d_data_valid, 0);
            step();
        end
        clear_inputs();
        repeat (5) step();

        chk(exp_i.size() == 0, "i_words_missing", exp_i.size(), 0);
        chk(exp_d.size() == 0, "d_words_missing", exp_d.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
